rv32i_dmem_if: RTL and testbench

//  Data-memory interface stage directly downstream of the RV32I ALU. Consumes the ALU's load/store

---
 rtl/rv32i_dmem_if_pkg.sv | 34 +++
 rtl/rv32i_dmem_if_if.sv | 47 ++++
 rtl/rv32i_dmem_if_wbuf.sv | 70 +++++++
 rtl/rv32i_dmem_if.sv | 167 ++++++++++++++++
 tb/tb_rv32i_dmem_if.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_dmem_if_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_if_pkg
// Shared definitions for the RV32I data-memory interface stage:
//   - load FSM state encoding
//   - write-buffer entry layout (30b word address, 4b byte enables, 32b data)
//   - helper to rebuild a byte address from a word address
// No ports; imported by the interface, the write buffer and the top level.
// -----------------------------------------------------------------------------
package rv32i_dmem_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int BE_W        = 4;
    localparam int DATA_W      = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Packed MSB-first: word_addr occupies [65:36], be [35:32], data [31:0].
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] word_addr;
        logic [BE_W-1:0]        be;
        logic [DATA_W-1:0]      data;
    } wbuf_entry_t;

    function automatic logic [31:0] byte_address(input logic [WORD_ADDR_W-1:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_dmem_if_if.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_if_if
// Waitrequest/readdatavalid memory bus between the data-memory interface
// stage (master) and the memory (slave).
//   address       32  byte address, always word aligned
//   write          1  write strobe
//   writedata     32  write data
//   byteenable     4  byte lanes (all set on reads)
//   read           1  read strobe
//   readdata      32  read data
//   waitrequest    1  slave not accepting; master holds the command
//   readdatavalid  1  readdata valid this cycle
// -----------------------------------------------------------------------------
interface rv32i_dmem_if_if;

    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;

    modport master (
        output address,
        output write,
        output writedata,
        output byteenable,
        output read,
        input  readdata,
        input  waitrequest,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  byteenable,
        input  read,
        output readdata,
        output waitrequest,
        output readdatavalid
    );

endinterface

// File: rtl/rv32i_dmem_if_wbuf.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_if_wbuf
// Posted-write buffer: synchronous FIFO of WBUF_DEPTH store entries.
//   clk, reset   clock, asynchronous active-high reset (pointers only)
//   push         enqueue push_entry on this edge
//   push_entry   store entry {word_addr, be, data}
//   pop          dequeue the head on this edge
//   head         oldest entry (valid when !empty)
//   count        occupancy, 0..WBUF_DEPTH
//   empty, full  occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// -----------------------------------------------------------------------------
module rv32i_dmem_if_wbuf
    import rv32i_dmem_if_pkg::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  wbuf_entry_t                   push_entry,
    input  logic                          pop,
    output wbuf_entry_t                   head,
    output logic [$clog2(WBUF_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);

    wbuf_entry_t      entries [WBUF_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(WBUF_DEPTH));
    assign head  = entries[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is pure data; stale contents are never read while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    // Upstream must honour stall; a store into a full buffer would be lost.
    assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/rv32i_dmem_if.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_if
// Data-memory interface stage downstream of the RV32I ALU. Stores are posted
// into a write buffer and drained onto the bus in the background; loads drain
// the buffer (keeping program order), issue a read and stall the pipeline
// until the data returns.
//   clk          system clock
//   reset        asynchronous active-high reset
//   load         load request, held until clr_load_op
//   store        one-cycle store pulse
//   addr         word-aligned access address ([1:0] ignored)
//   st_be        store byte enables
//   wr_data      lane-shifted store data
//   ld_data      raw load word
//   clr_load_op  load complete, ld_data valid this cycle
//   stall        pipeline stall
//   wbuf_empty   no buffered or in-flight write (FENCE support)
//   bus          memory bus master (rv32i_dmem_if_if.master)
// -----------------------------------------------------------------------------
module rv32i_dmem_if
    import rv32i_dmem_if_pkg::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                store,
    input  logic [31:0]         addr,
    input  logic [3:0]          st_be,
    input  logic [31:0]         wr_data,
    output logic [31:0]         ld_data,
    output logic                clr_load_op,
    output logic                stall,
    output logic                wbuf_empty,
    rv32i_dmem_if_if.master     bus
);

    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    state_t                 state_q;
    state_t                 state_d;
    logic [WORD_ADDR_W-1:0] load_addr_q;

    wbuf_entry_t            push_entry;
    wbuf_entry_t            head;
    logic [CNT_W-1:0]       wb_count;
    logic                   wb_empty;
    logic                   wb_full;
    logic                   drain_active;
    logic                   wb_pop;
    logic                   wbuf_nearly_full;
    logic                   addr_lsb_unused;

    assign addr_lsb_unused = ^addr[1:0];

    assign push_entry = '{word_addr: addr[31:2], be: st_be, data: wr_data};

    rv32i_dmem_if_wbuf #(
        .WBUF_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (store),
        .push_entry (push_entry),
        .pop        (wb_pop),
        .head       (head),
        .count      (wb_count),
        .empty      (wb_empty),
        .full       (wb_full)
    );

    // Writes only drain while no read is being issued or awaited, which keeps
    // the two bus strobes mutually exclusive by construction.
    assign drain_active = ((state_q == IDLE) || (state_q == DRAIN)) && !wb_empty;
    assign wb_pop       = drain_active && !bus.waitrequest;

    // One slot is kept in reserve for a store already issued in the cycle
    // stall rises.
    assign wbuf_nearly_full = (wb_count >= CNT_W'(WBUF_DEPTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load && !clr_load_op) begin
                    // A store coinciding with the load start is pushed this
                    // edge, so it must drain before the read is issued.
                    if (wb_empty && !store) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wb_empty) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!bus.waitrequest) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.readdatavalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        clr_load_op    = (state_q == DONE);
        stall          = wbuf_nearly_full;
        wbuf_empty     = wb_empty && !drain_active;

        if (state_q == RD_REQ) begin
            bus.read       = 1'b1;
            bus.address    = byte_address(load_addr_q);
            bus.byteenable = 4'b1111;
        end else if (drain_active) begin
            bus.write      = 1'b1;
            bus.address    = byte_address(head.word_addr);
            bus.writedata  = head.data;
            bus.byteenable = head.be;
        end

        if (((state_q == IDLE) && load) ||
            (state_q == DRAIN) || (state_q == RD_REQ) || (state_q == RD_WAIT)) begin
            stall = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ld_data <= '0;
        end else begin
            state_q <= state_d;
            // Data returning in any other state belongs to an abandoned access.
            if ((state_q == RD_WAIT) && bus.readdatavalid) begin
                ld_data <= bus.readdata;
            end
        end
    end

    // Load address is captured as the FSM leaves IDLE and held for the read.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && (state_d != IDLE)) begin
            load_addr_q <= addr[31:2];
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_if.sv
// -----------------------------------------------------------------------------
// tb_rv32i_dmem_if
// Directed bench for rv32i_dmem_if: stimulus pushes expected bus writes, bus
// reads and load completions into a queue; a monitor pops and compares them
// as the DUT presents accepted transactions.
// -----------------------------------------------------------------------------
module tb_rv32i_dmem_if;
    import rv32i_dmem_if_pkg::*;

    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_LD = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  st_be = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] ld_data;
    logic        clr_load_op;
    logic        stall;
    logic        wbuf_empty;

    logic        rd_pend = 1'b0;
    logic        suppress_rdv = 1'b0;
    logic        force_rdv = 1'b0;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    rv32i_dmem_if_if bus ();

    rv32i_dmem_if #(
        .WBUF_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .store       (store),
        .addr        (addr),
        .st_be       (st_be),
        .wr_data     (wr_data),
        .ld_data     (ld_data),
        .clr_load_op (clr_load_op),
        .stall       (stall),
        .wbuf_empty  (wbuf_empty),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.be   = be;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic compare_next(input logic [1:0] kind, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected kind actual=%0d required=none", kind);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (kind != K_LD) begin
                chk("sb_addr", a, e.addr);
                chk("sb_be", 32'(be), 32'(e.be));
            end
            if (kind != K_RD) begin
                chk("sb_data", d, e.data);
            end
        end
    endtask

    // Monitor: accepted bus commands and load completions.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.write || bus.read) begin
                chk("strobe_exclusive", 32'(bus.write & bus.read), 32'd0);
            end
            if (bus.write && !bus.waitrequest) begin
                compare_next(K_WR, bus.address, bus.byteenable, bus.writedata);
            end
            if (bus.read && !bus.waitrequest) begin
                compare_next(K_RD, bus.address, bus.byteenable, 32'd0);
            end
            if (clr_load_op) begin
                compare_next(K_LD, 32'd0, 4'd0, ld_data);
            end
        end
    end

    // Memory responder: readdatavalid one cycle after a read is accepted.
    initial begin
        bus.readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            bus.readdatavalid = rd_pend | force_rdv;
            rd_pend = bus.read && !bus.waitrequest && !suppress_rdv;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clr(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (clr_load_op) break;
        end
        if (!clr_load_op) chk("clr_timeout", 32'(clr_load_op), 32'd1);
    endtask

    initial begin
        int n;
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;

        // Reset state
        #12;
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_clr", 32'(clr_load_op), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_read", 32'(bus.read), 32'd0);
        chk("rst_address", bus.address, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single posted store, zero-wait bus
        store = 1'b1; addr = 32'h100; st_be = 4'b0011; wr_data = 32'h0000BEEF;
        push_exp(K_WR, 32'h100, 4'b0011, 32'h0000BEEF);
        tick();
        store = 1'b0;
        chk("t1_write", 32'(bus.write), 32'd1);
        chk("t1_wbuf_empty_busy", 32'(wbuf_empty), 32'd0);
        chk("t1_stall", 32'(stall), 32'd0);
        tick();
        chk("t1_write_done", 32'(bus.write), 32'd0);
        chk("t1_wbuf_empty_done", 32'(wbuf_empty), 32'd1);

        // 2: four stores into a blocked bus
        bus.waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store = 1'b1;
            addr = 32'h400 + 32'(4 * i);
            st_be = 4'b0001 << i;
            wr_data = 32'h11110000 + 32'(i);
            push_exp(K_WR, addr, st_be, wr_data);
            tick();
            store = 1'b0;
            chk("t2_stall", 32'(stall), (i >= 2) ? 32'd1 : 32'd0);
        end
        chk("t2_head_held", bus.address, 32'h400);
        bus.waitrequest = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wbuf_empty) break;
            tick();
        end
        chk("t2_drained", 32'(wbuf_empty), 32'd1);
        chk("t2_stall_after", 32'(stall), 32'd0);

        // 3: load from empty buffer, minimum latency
        bus.readdata = 32'h12345678;
        load = 1'b1; addr = 32'h200;
        push_exp(K_RD, 32'h200, 4'hF, 32'd0);
        push_exp(K_LD, 32'd0, 4'd0, 32'h12345678);
        #1;
        chk("t3_stall_first", 32'(stall), 32'd1);
        wait_clr(n);
        chk("t3_latency", 32'(n), 32'd3);
        chk("t3_ld_data", ld_data, 32'h12345678);
        chk("t3_stall_done", 32'(stall), 32'd0);
        load = 1'b0;
        tick();

        // 4: store then load of the same address
        bus.readdata = 32'h0BADC0DE;
        store = 1'b1; addr = 32'h300; st_be = 4'hF; wr_data = 32'hCAFEF00D;
        push_exp(K_WR, 32'h300, 4'hF, 32'hCAFEF00D);
        tick();
        store = 1'b0;
        load = 1'b1;
        push_exp(K_RD, 32'h300, 4'hF, 32'd0);
        push_exp(K_LD, 32'd0, 4'd0, 32'h0BADC0DE);
        wait_clr(n);
        chk("t4_ld_data", ld_data, 32'h0BADC0DE);
        load = 1'b0;
        tick();

        // 4b: store pulse coincident with load start
        bus.readdata = 32'h77777777;
        store = 1'b1; load = 1'b1; addr = 32'h500; st_be = 4'b1100; wr_data = 32'h55AA55AA;
        push_exp(K_WR, 32'h500, 4'b1100, 32'h55AA55AA);
        push_exp(K_RD, 32'h500, 4'hF, 32'd0);
        push_exp(K_LD, 32'd0, 4'd0, 32'h77777777);
        tick();
        store = 1'b0;
        wait_clr(n);
        chk("t4b_ld_data", ld_data, 32'h77777777);
        load = 1'b0;
        tick();

        // 5: read held by waitrequest
        bus.waitrequest = 1'b1;
        bus.readdata = 32'hA5A50001;
        load = 1'b1; addr = 32'h600;
        push_exp(K_RD, 32'h600, 4'hF, 32'd0);
        push_exp(K_LD, 32'd0, 4'd0, 32'hA5A50001);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_read_held", 32'(bus.read), 32'd1);
            chk("t5_addr_held", bus.address, 32'h600);
            chk("t5_stall_held", 32'(stall), 32'd1);
            tick();
        end
        bus.waitrequest = 1'b0;
        wait_clr(n);
        chk("t5_ld_data", ld_data, 32'hA5A50001);
        load = 1'b0;
        tick();

        // 6: reset in RD_WAIT, stray readdatavalid afterwards
        suppress_rdv = 1'b1;
        load = 1'b1; addr = 32'h700;
        push_exp(K_RD, 32'h700, 4'hF, 32'd0);
        tick();
        tick();
        chk("t6_wait_stall", 32'(stall), 32'd1);
        chk("t6_wait_read", 32'(bus.read), 32'd0);
        reset = 1'b1;
        load = 1'b0;
        #1;
        chk("t6_rst_clr", 32'(clr_load_op), 32'd0);
        chk("t6_rst_stall", 32'(stall), 32'd0);
        chk("t6_rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
        chk("t6_rst_read", 32'(bus.read), 32'd0);
        chk("t6_rst_ld_data", ld_data, 32'd0);
        tick();
        reset = 1'b0;
        suppress_rdv = 1'b0;
        bus.readdata = 32'hDEADDEAD;
        force_rdv = 1'b1;
        tick();
        force_rdv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_clr", 32'(clr_load_op), 32'd0);
            chk("t6_ld_data_kept", ld_data, 32'd0);
        end

        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
